axis_burst_tx: RTL and testbench
================================

// Module: axis_burst_tx
// PURPOSE
//  AXI-Stream transmitter for memory read bursts. Accepts burst commands, forwards them to the
//  memory controller, and buffers the returned read beats. Read beats cannot be stalled.
//  Emits each burst as one AXI-S frame, with tlast on the final beat.
//  Sits between the DDR3 controller read-data path and an AXI-S consumer, or an axis_skid.
//  Buffer space is reserved per command, so read data can never overflow.
// PARAMETERS
//  WIDTH   32  data width (tdata, rd_data)
//  LBITS   4   burst-length field width; burst = cmd_len+1 beats (1..2**LBITS)
//  DEPTH   32  data-FIFO words; power of 2, must be >= 2**LBITS (elaboration error otherwise)
//  CMDQ    4   length-queue entries; power of 2, >= 2
// PORTS
//  clock      in   1      system clock
//  reset      in   1      synchronous, active-high
//  cmd_valid  in   1      burst command valid
//  cmd_ready  out  1      burst command accepted this cycle (when cmd_valid is also high)
//  cmd_len    in   LBITS  beats-1 of the requested burst
//  req_valid  out  1      request to memory controller
//  req_ready  in   1      memory controller accepts request
//  req_len    out  LBITS  equals cmd_len
//  rd_valid   in   1      read beat present; no backpressure
//  rd_data    in   WIDTH  read beat data
//  m_tvalid   out  1      AXI-S valid
//  m_tready   in   1      AXI-S ready
//  m_tlast    out  1      final beat of current burst
//  m_tdata    out  WIDTH  AXI-S data
//  overflow   out  1      sticky: rd_valid arrived while the data FIFO was full
// BEHAVIOUR
//  Reset state and outputs:
//   - credits=DEPTH; FIFO and length queue empty; beat counter = 0.
//   - m_tvalid=0, overflow=0; req_valid/cmd_ready low unless their terms below hold.
//   - reset mid-burst discards all buffered data and pending lengths; the controller is reset too.
//  Admission (combinational):
//   - ok = (credits >= cmd_len+1) && !lenq_full
//   - req_valid = cmd_valid && ok
//   - cmd_ready = req_ready && ok
//   - req_len = cmd_len
//   - accept = cmd_valid && cmd_ready; on accept, push cmd_len into the length queue.
//  Credits (width clog2(DEPTH)+1):
//   - next = credits - (accept ? cmd_len+1 : 0) + (pop ? 1 : 0)
//   - pop = m_tvalid && m_tready; accept and pop in the same cycle apply both.
//  Data FIFO:
//   - rd_valid writes mem[wr_ptr] every cycle it is high; pointers wrap modulo DEPTH.
//   - a write while full is dropped and sets overflow; this is unreachable when credits are honoured.
//   - read is asynchronous (m_tdata = mem[rd_ptr]), so rd_valid in cycle N gives m_tvalid in cycle N+1
//     when the FIFO was empty.
//   - simultaneous write and pop keeps the count unchanged; a write to an empty FIFO with no pop is legal.
//  Framing:
//   - m_tvalid = !fifo_empty && !lenq_empty
//   - m_tlast = m_tvalid && (beat == lenq_head)
//   - on pop: if m_tlast, then beat<=0 and the length queue pops; else beat<=beat+1.
//   - m_tdata, m_tlast and m_tvalid hold stable while m_tvalid && !m_tready (AXI-S rule).
//   - back-to-back bursts: the first beat of the next frame may follow tlast in the next cycle.
//  Throughput: 1 beat/cycle sustained; with cmd_len=0 every beat carries tlast.
// STRUCTURE
//  - Shared package/include: default WIDTH/LBITS, and a clog2 helper used for pointer and credit widths.
//  - One sub-module, sync_fifo (WIDTH, DEPTH, first-word-fall-through, async read), used for data.
//    A second instance (LBITS, CMDQ) is used for the length queue.
//  - Credit counter, admission logic and beat counter sit in this module.
// TESTING
//  1. Single burst: cmd_len=3; 4 rd_valid beats D0..D3; m_tready=1.
//     -> D0..D3 out, tlast only on D3; credits return to 32.
//  2. Backpressure: same as test 1 with m_tready toggling 1,0,0,1.
//     -> tdata/tlast stable while stalled; no beat lost or duplicated.
//  3. Credit limit: DEPTH=32, LBITS=4, m_tready=0; issue cmd_len=15 twice, then cmd_len=0.
//     -> first two accepted; third has cmd_ready=0 until the first pop frees a credit.
//  4. Queue full: CMDQ=4; five cmd_len=0 commands with no read data.
//     -> fifth held (cmd_ready=0) until one frame completes.
//  5. Simultaneous events: accept and pop in the same cycle.
//     -> credits change by exactly -(len+1)+1; FIFO write and pop together keep the count unchanged.
//  6. Reset mid-burst: reset after 2 of 4 beats are output.
//     -> m_tvalid=0 the next cycle, credits=32, overflow=0.
//     -> a new cmd_len=1 burst then frames correctly.

Source files
------------

// File: rtl/axis_burst_tx_pkg.sv
// Shared defaults and helpers for the AXI-S burst transmitter.
// Imported by the FIFO and the top level.
package axis_burst_tx_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LBITS_DEF = 4;
  localparam int DEPTH_DEF = 32;
  localparam int CMDQ_DEF  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_burst_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, asynchronous read port.
// A write while full is dropped; the caller flags it.
module sync_fifo
  import axis_burst_tx_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = clog2(D);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [D];
  logic         wr_ok;
  logic         rd_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/axis_burst_tx.sv
// AXI-S transmitter for memory read bursts.
// Credits reserve FIFO space per command so read beats never stall.
module axis_burst_tx
  import axis_burst_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LBITS = LBITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CMDQ  = CMDQ_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LBITS-1:0] cmd_len,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [LBITS-1:0] req_len,
  input  logic             rd_valid,
  input  logic [WIDTH-1:0] rd_data,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic             overflow
);

  localparam int CW = clog2(DEPTH) + 1;

  generate
    if (DEPTH < (1 << LBITS) || (1 << clog2(DEPTH)) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and >= 2**LBITS");
    end
    if (CMDQ < 2 || (1 << clog2(CMDQ)) != CMDQ) begin : g_bad_cmdq
      $error("CMDQ must be a power of 2 and >= 2");
    end
  endgenerate

  logic [CW-1:0]    credits_q, credits_d;
  logic [LBITS-1:0] beat_q, beat_d;
  logic             overflow_q, overflow_d;
  logic [CW-1:0]    need;
  logic             ok;
  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             lenq_full;
  logic             lenq_empty;
  logic [LBITS-1:0] lenq_head;

  assign need      = CW'(cmd_len) + CW'(1);
  assign ok        = (credits_q >= need) && !lenq_full;
  assign req_valid = cmd_valid && ok;
  assign cmd_ready = req_ready && ok;
  assign req_len   = cmd_len;
  assign accept    = cmd_valid && cmd_ready;

  assign m_tvalid = !fifo_empty && !lenq_empty;
  assign m_tlast  = m_tvalid && (beat_q == lenq_head);
  assign pop      = m_tvalid && m_tready;
  assign overflow = overflow_q;

  sync_fifo #(
    .W(WIDTH),
    .D(DEPTH)
  ) u_data (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (rd_valid),
    .wr_data_i (rd_data),
    .rd_en_i   (pop),
    .rd_data_o (m_tdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  sync_fifo #(
    .W(LBITS),
    .D(CMDQ)
  ) u_lenq (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (accept),
    .wr_data_i (cmd_len),
    .rd_en_i   (pop && m_tlast),
    .rd_data_o (lenq_head),
    .full_o    (lenq_full),
    .empty_o   (lenq_empty)
  );

  // Credit, beat and sticky-overflow next state.
  always_comb begin
    credits_d  = credits_q;
    beat_d     = beat_q;
    overflow_d = overflow_q | (rd_valid && fifo_full);
    if (accept) credits_d = credits_d - need;
    if (pop) begin
      credits_d = credits_d + CW'(1);
      if (m_tlast) beat_d = '0;
      else         beat_d = beat_q + 1'b1;
    end
  end

  // State registers; reset returns every credit.
  always_ff @(posedge clock) begin
    if (reset) begin
      credits_q  <= CW'(DEPTH);
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_axis_burst_tx.sv
// Randomized scoreboard bench for axis_burst_tx.
// Expected frames come from accepted commands and the beats returned for them.
module tb_axis_burst_tx;

  localparam int WIDTH = 32;
  localparam int LBITS = 4;
  localparam int DEPTH = 32;
  localparam int CMDQ  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LBITS-1:0] cmd_len;
  logic             req_valid;
  logic             req_ready;
  logic [LBITS-1:0] req_len;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [WIDTH-1:0] m_tdata;
  logic             overflow;

  always #5 clock = ~clock;

  axis_burst_tx #(
    .WIDTH(WIDTH),
    .LBITS(LBITS),
    .DEPTH(DEPTH),
    .CMDQ (CMDQ)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tdata   (m_tdata),
    .overflow  (overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    granted[$];
  bit    pend[$];
  int    outstanding;
  int    frames;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: command source, memory model, sink readiness.
  task automatic step(input int p_cmd, input int p_rdy, input bit do_rst);
    int r;
    int len;
    @(posedge clock);
    #1;
    while (granted.size() > 0) begin
      len = granted.pop_front();
      for (int i = 0; i <= len; i++) pend.push_back(i == len);
    end
    if (do_rst) begin
      reset     = 1'b1;
      pend.delete();
      cmd_valid = 1'b0;
      rd_valid  = 1'b0;
      m_tready  = 1'b0;
      req_ready = 1'b0;
      return;
    end
    reset     = 1'b0;
    cmd_valid = ($urandom_range(0, 99) < p_cmd);
    r = $urandom_range(0, 3);
    if (r == 0)      cmd_len = '0;
    else if (r == 1) cmd_len = '1;
    else             cmd_len = LBITS'($urandom_range(0, 15));
    req_ready = ($urandom_range(0, 7) != 0);
    m_tready  = ($urandom_range(0, 99) < p_rdy);
    rd_data   = $urandom;
    if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
      rd_valid = 1'b1;
      sb.push_back('{rd_data, pend.pop_front()});
    end else begin
      rd_valid = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    req_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    m_tready  = 1'b0;
    repeat (3) @(posedge clock);
    for (int i = 0; i < 300; i++) step(50, 100, 1'b0);
    for (int i = 0; i < 300; i++) step(60, 30, 1'b0);
    for (int i = 0; i < 150; i++) step(80, 0, 1'b0);
    for (int i = 0; i < 200; i++) step(50, 60, i == 100);
    for (int i = 0; i < 150; i++) step(70, 0, 1'b0);
    for (int i = 0; i < 40; i++)  step(40, 100, i == 20);
    for (int i = 0; i < 300; i++) step(50, 80, 1'b0);
    for (int i = 0; i < 200; i++) step(0, 100, 1'b0);
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_outstanding", 64'(outstanding), 64'd0);
    check("drain_pending", 64'(pend.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  bit               just_reset = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_d;
  logic             prev_l;

  // Monitor: admission rules, AXI-S stability and scoreboard compare.
  always @(negedge clock) begin
    bit    ok;
    beat_t e;
    if (reset) begin
      sb.delete();
      granted.delete();
      outstanding = 0;
      frames      = 0;
      prev_stall  = 1'b0;
      just_reset  = 1'b1;
    end else begin
      if (just_reset) begin
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        just_reset = 1'b0;
      end
      ok = ((DEPTH - outstanding) >= (int'(cmd_len) + 1)) && (frames < CMDQ);
      check("cmd_ready", 64'(cmd_ready), 64'(req_ready && ok));
      check("req_valid", 64'(req_valid), 64'(cmd_valid && ok));
      if (req_valid) check("req_len", 64'(req_len), 64'(cmd_len));
      check("overflow", 64'(overflow), 64'd0);
      if (sb.size() == 0) check("idle_tvalid", 64'(m_tvalid), 64'd0);
      if (prev_stall) begin
        check("hold_tvalid", 64'(m_tvalid), 64'd1);
        check("hold_tdata", 64'(m_tdata), 64'(prev_d));
        check("hold_tlast", 64'(m_tlast), 64'(prev_l));
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("sb_empty_pop", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("tdata", 64'(m_tdata), 64'(e.d));
          check("tlast", 64'(m_tlast), 64'(e.l));
          outstanding = outstanding - 1;
          if (e.l) frames = frames - 1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        granted.push_back(int'(cmd_len));
        outstanding = outstanding + int'(cmd_len) + 1;
        frames      = frames + 1;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end
  end

endmodule
